upsampler_param: RTL

UPSAMPLER_PARAM -- requirements
Module: upsampler_param

---
 rtl/upsampler_pkg.sv | 24 ++
 rtl/upsampler_if.sv | 28 ++
 rtl/upsampler_param_line_buffer.sv | 25 ++
 rtl/upsampler_param.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/upsampler_pkg.sv
// Shared types and elaboration helpers for the integer-factor pixel upsampler.
package upsampler_pkg;

   typedef enum logic {FIRST = 1'b0, REPEAT = 1'b1} state_e;
   typedef enum logic {REPLICATE = 1'b0, ZERO_STUFF = 1'b1} mode_e;

   // Bit n set means SCALE=n is supported (1, 2, 4).
   localparam logic [4:0] LEGAL_SCALE_MASK = 5'b10110;

   function automatic bit scale_legal(input int unsigned s);
      logic [2:0] w_idx;
      w_idx = s[2:0];
      return (s < 5) ? LEGAL_SCALE_MASK[w_idx] : 1'b0;
   endfunction

   function automatic int unsigned cw(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned scale_shift(input int unsigned s);
      return (s == 4) ? 2 : ((s == 2) ? 1 : 0);
   endfunction

endpackage

// File: rtl/upsampler_if.sv
// Pixel stream bundle: input valid/ready, output valid/ready with frame markers and coordinates.
interface upsampler_if #(
   parameter int DATA_W = 8,
   parameter int ROW_W  = 10,
   parameter int COL_W  = 10
);
   logic              mode;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              out_sof;
   logic              out_eol;
   logic [ROW_W-1:0]  out_row;
   logic [COL_W-1:0]  out_col;

   modport master (
      output mode, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sof, out_eol, out_row, out_col
   );

   modport slave (
      input  mode, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sof, out_eol, out_row, out_col
   );
endinterface

// File: rtl/upsampler_param_line_buffer.sv
// One input line of pixels: synchronous write, asynchronous read.
module line_buffer
   import upsampler_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 400,
   parameter int ADDR_W = cw(DEPTH)
) (
   input  logic              clock,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];
endmodule

// File: rtl/upsampler_param.sv
// Integer upsampler (x1/x2/x4), replicate or zero-stuff; output registered, latency 1 from input accept.
// Output register reloads only when empty or taken, so out_ready stalls freeze the whole pipeline.
module upsampler_param
   import upsampler_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int IN_COLS = 400,
   parameter int IN_ROWS = 300,
   parameter int SCALE   = 2
) (
   input logic        clock,
   input logic        reset_n,
   upsampler_if.slave bus
);
   localparam int HP_W  = cw(SCALE);
   localparam int IC_W  = cw(IN_COLS);
   localparam int IR_W  = cw(IN_ROWS);
   localparam int ROW_W = cw(IN_ROWS * SCALE);
   localparam int COL_W = cw(IN_COLS * SCALE);
   localparam int SHIFT = scale_shift(SCALE);
   localparam logic [HP_W-1:0] HP_LAST = HP_W'(SCALE - 1);
   localparam logic [IC_W-1:0] IC_LAST = IC_W'(IN_COLS - 1);
   localparam logic [IR_W-1:0] IR_LAST = IR_W'(IN_ROWS - 1);

   if (!scale_legal(SCALE)) begin : g_bad_scale
      $error("upsampler_param: SCALE must be 1, 2 or 4");
   end

   state_e            r_state;
   mode_e             r_mode;
   logic              r_run;
   logic [HP_W-1:0]   r_hphase;
   logic [IC_W-1:0]   r_icol;
   logic [HP_W-1:0]   r_vphase;
   logic [IR_W-1:0]   r_irow;
   logic [DATA_W-1:0] r_hold;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_sof;
   logic              r_out_eol;
   logic [ROW_W-1:0]  r_out_row;
   logic [COL_W-1:0]  r_out_col;

   state_e            w_state_nxt;
   logic [HP_W-1:0]   w_hphase_nxt;
   logic [IC_W-1:0]   w_icol_nxt;
   logic [HP_W-1:0]   w_vphase_nxt;
   logic [IR_W-1:0]   w_irow_nxt;
   logic              w_advance;
   logic              w_need_in;
   logic              w_produce;
   logic              w_accept;
   logic              w_frame_start;
   logic              w_eol;
   logic [DATA_W-1:0] w_pix;
   logic [DATA_W-1:0] w_lb_rdata;
   logic [ROW_W-1:0]  w_row;
   logic [COL_W-1:0]  w_col;

   always_comb begin
      w_advance     = !r_out_valid || bus.out_ready;
      w_need_in     = (r_state == FIRST) && (r_hphase == '0);
      w_accept      = r_run && w_advance && w_need_in && bus.in_valid;
      w_produce     = r_run && w_advance && (w_need_in ? bus.in_valid : 1'b1);
      w_frame_start = (r_hphase == '0) && (r_icol == '0) && (r_vphase == '0) && (r_irow == '0);
      w_eol         = (r_icol == IC_LAST) && (r_hphase == HP_LAST);
      w_pix         = '0;
      if (r_state == FIRST) begin
         if (w_need_in) begin
            w_pix = bus.in_data;
         end else if (r_mode == REPLICATE) begin
            w_pix = r_hold;
         end
      end else if (r_mode == REPLICATE) begin
         w_pix = w_lb_rdata;
      end

      w_hphase_nxt = r_hphase;
      w_icol_nxt   = r_icol;
      w_vphase_nxt = r_vphase;
      w_irow_nxt   = r_irow;
      if (w_produce) begin
         if (r_hphase == HP_LAST) begin
            w_hphase_nxt = '0;
            if (r_icol == IC_LAST) begin
               w_icol_nxt = '0;
               if (r_vphase == HP_LAST) begin
                  w_vphase_nxt = '0;
                  w_irow_nxt   = (r_irow == IR_LAST) ? '0 : r_irow + 1'b1;
               end else begin
                  w_vphase_nxt = r_vphase + 1'b1;
               end
            end else begin
               w_icol_nxt = r_icol + 1'b1;
            end
         end else begin
            w_hphase_nxt = r_hphase + 1'b1;
         end
      end
      w_state_nxt = (w_vphase_nxt == '0) ? FIRST : REPEAT;
   end

   // SCALE is a power of two, so the output coordinate is the input index with the phase in its low bits.
   assign w_col = (COL_W'(r_icol) << SHIFT) | COL_W'(r_hphase);
   assign w_row = (ROW_W'(r_irow) << SHIFT) | ROW_W'(r_vphase);

   if (SCALE > 1) begin : g_lb
      line_buffer #(
         .DATA_W (DATA_W),
         .DEPTH  (IN_COLS)
      ) u_line_buffer (
         .clock     (clock),
         .i_wr_en   (w_accept),
         .i_wr_addr (r_icol),
         .i_wr_data (bus.in_data),
         .i_rd_addr (r_icol),
         .o_rd_data (w_lb_rdata)
      );
   end else begin : g_no_lb
      assign w_lb_rdata = '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= FIRST;
         r_mode      <= REPLICATE;
         r_run       <= 1'b0;
         r_hphase    <= '0;
         r_icol      <= '0;
         r_vphase    <= '0;
         r_irow      <= '0;
         r_hold      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sof   <= 1'b0;
         r_out_eol   <= 1'b0;
         r_out_row   <= '0;
         r_out_col   <= '0;
      end else begin
         r_run    <= 1'b1;
         r_state  <= w_state_nxt;
         r_hphase <= w_hphase_nxt;
         r_icol   <= w_icol_nxt;
         r_vphase <= w_vphase_nxt;
         r_irow   <= w_irow_nxt;
         if (w_accept) begin
            r_hold <= bus.in_data;
            if (w_frame_start) begin
               r_mode <= mode_e'(bus.mode);
            end
         end
         if (w_advance) begin
            r_out_valid <= w_produce;
            if (w_produce) begin
               r_out_data <= w_pix;
               r_out_sof  <= w_frame_start;
               r_out_eol  <= w_eol;
               r_out_row  <= w_row;
               r_out_col  <= w_col;
            end
         end
      end
   end

   assign bus.in_ready  = r_run && w_advance && w_need_in;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_sof   = r_out_sof;
   assign bus.out_eol   = r_out_eol;
   assign bus.out_row   = r_out_row;
   assign bus.out_col   = r_out_col;
endmodule
